lane_combat_ctrl: RTL and testbench
===================================

Name: lane_combat_ctrl

Overview:
- Per-lane referee on the responder side of the unit interface: it consumes each unit's position/damageOut/dead and drives that unit's moveSCEN/damageSCEN/damageIn.
- One player unit (moves toward position 0) and one enemy unit (moves toward MAX_POS) share a lane.
- On every game tick it decides whether the units fight or advance, and applies base damage when a unit reaches the far end.
- Sits between the unit instances and the top-level score/display logic.

Parameters:
- MAX_POS, 9'd510, enemy destination (player base); player destination is 9'd0.
- RANGE, 9'd1, contact distance; units fight when pPosition - ePosition <= RANGE.
- BASE_HP, 8'd255, initial health of each base.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- gameTick  in  1  single-cycle strobe, synchronous to clk, one per game step
- pAlive  in  1  player unit deployed and not dead
- pPosition  in  9  player unit position
- pDamageOut  in  8  player unit attack power
- eAlive  in  1  enemy unit deployed and not dead
- ePosition  in  9  enemy unit position
- eDamageOut  in  8  enemy unit attack power
- pMoveSCEN  out  1  player move strobe
- pDamageSCEN  out  1  player take-damage strobe
- pDamageIn  out  8  damage applied to player
- eMoveSCEN  out  1  enemy move strobe
- eDamageSCEN  out  1  enemy take-damage strobe
- eDamageIn  out  8  damage applied to enemy
- playerBaseHP  out  8  player base health
- enemyBaseHP  out  8  enemy base health
- gameOver  out  1  sticky; a base reached 0
- playerWins  out  1  valid when gameOver; 1 = enemy base destroyed
- tickOverrun  out  1  sticky; gameTick arrived while not IDLE

Behaviour:
- Reset values: all strobes 0, damage buses 0, both base HPs = BASE_HP, gameOver/playerWins/tickOverrun 0, state IDLE.
- States: IDLE, EVAL, APPLY, OVER.
- IDLE, gameTick=1: go to EVAL. The same edge snapshots all unit inputs into registers.
- EVAL: computes the decision from the snapshot only; go to APPLY.
- APPLY: drives the strobes for exactly one cycle, updates base HPs, then goes to IDLE, or to OVER if either base HP is now 0.
- Latency: gameTick at cycle t produces strobes high during cycle t+2 only.
- Contact: both alive AND (pPos < ePos OR pPos - ePos <= RANGE). Compute in 10 bits; no wrap.
- Contact case:
  - pDamageSCEN = eDamageSCEN = 1.
  - pDamageIn = eDamageOut, eDamageIn = pDamageOut.
  - Both move strobes 0.
- No-contact case, per alive unit:
  - Player with pPos != 0: pMoveSCEN = 1.
  - Player with pPos == 0: no move; enemyBaseHP -= pDamageOut.
  - Enemy with ePos != MAX_POS: eMoveSCEN = 1.
  - Enemy with ePos == MAX_POS: no move; playerBaseHP -= eDamageOut.
- Dead or undeployed units get all strobes 0.
- Base subtraction saturates at 0.
- Both bases reaching 0 in the same APPLY: gameOver=1, playerWins=0 (tie goes to the enemy).
- Damage buses hold their value outside APPLY and are meaningful only while the corresponding DamageSCEN is 1.
- gameTick while in EVAL or APPLY: ignored and tickOverrun set. The tick is not queued.
- OVER: absorbing until reset. All strobes held 0; HPs frozen.
- Reset asserted mid-operation: everything returns to reset values immediately, and any pending strobes are cancelled.

Decomposition:
- Shared package lane_pkg holds:
  - State encoding: one-hot, 4 bits.
  - Position constants: PLAYER_SPAWN_POS = 9'h1FF, ENEMY_SPAWN_POS = 9'd0, MAX_POS.
  - BASE_HP.
  - Damage width: 8.
- One natural sub-module, base_hp_counter: saturating 8-bit down-counter with load value BASE_HP, subtract-enable, amount input and zero flag. Instantiated twice.

Test Plan:
- Player alive at pPos=100, enemy dead, gameTick -> exactly one cycle of pMoveSCEN=1 two cycles later; all other strobes 0.
- pPos=50, ePos=49, pDamageOut=8'h20, eDamageOut=8'h10, tick -> pDamageSCEN=eDamageSCEN=1, pDamageIn=8'h10, eDamageIn=8'h20, no move strobes.
- Player alive at pPos=0 with pDamageOut=8'h80 and no enemy; two ticks -> enemyBaseHP 255 -> 127 -> 0; then gameOver=1, playerWins=1, and a later tick produces no strobes.
- Player at pPos=0 and enemy at ePos=510, both with power 8'hFF, contact false (pPos < ePos but distance > RANGE is impossible here, so set RANGE=0 and pPos > ePos... use enemy-only variant):
  - Enemy at 510 with power 8'hFF, one tick -> playerBaseHP=0, gameOver=1, playerWins=0.
  - Separately, force both bases to 0 in one APPLY -> playerWins=0.
- Ticks at cycles t and t+1 -> one set of strobes at t+2 only; tickOverrun=1.
- Reset asserted during APPLY -> strobes drop to 0 immediately; HPs return to 255; state IDLE after release.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared definitions for the lane referee: state encoding, lane geometry,
// base health and the per-tick strobe decision.
package lane_pkg;

    localparam int DMG_W = 8;
    localparam int POS_W = 9;

    localparam logic [POS_W-1:0] PLAYER_SPAWN_POS = 9'h1FF;
    localparam logic [POS_W-1:0] ENEMY_SPAWN_POS  = 9'd0;
    localparam logic [POS_W-1:0] MAX_POS          = 9'd510;
    localparam logic [POS_W-1:0] RANGE            = 9'd1;
    localparam logic [DMG_W-1:0] BASE_HP          = 8'd255;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_EVAL  = 4'b0010,
        ST_APPLY = 4'b0100,
        ST_OVER  = 4'b1000
    } lane_state_t;

    typedef struct packed {
        logic p_move;
        logic p_hit;
        logic e_move;
        logic e_hit;
    } decision_t;

    // Units touch once they have crossed or sit within range of each other;
    // the difference is taken one bit wider so it never wraps.
    function automatic logic in_contact(input logic [POS_W-1:0] p_pos,
                                        input logic [POS_W-1:0] e_pos,
                                        input logic [POS_W-1:0] range);
        logic [POS_W:0] diff;
        diff = {1'b0, p_pos} - {1'b0, e_pos};
        return (p_pos < e_pos) || (diff <= {1'b0, range});
    endfunction

endpackage

// File: rtl/base_hp_counter.sv
// Saturating down-counter holding one base's health; loads LOAD on reset.
module base_hp_counter
    import lane_pkg::*;
#(
    parameter logic [DMG_W-1:0] LOAD = BASE_HP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sub_en,
    input  logic [DMG_W-1:0] amount,
    output logic [DMG_W-1:0] count,
    output logic             zero
);

    logic [DMG_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (sub_en) begin
            count_next = (amount >= count) ? '0 : count - amount;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LOAD;
        end else begin
            count <= count_next;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lane_combat_ctrl.sv
// Per-lane referee: on each game tick decides whether the two units fight,
// advance or strike the opposing base, and tracks both base health counters.
module lane_combat_ctrl
    import lane_pkg::*;
#(
    parameter logic [POS_W-1:0] MAX_POS = lane_pkg::MAX_POS,
    parameter logic [POS_W-1:0] RANGE   = lane_pkg::RANGE,
    parameter logic [DMG_W-1:0] BASE_HP = lane_pkg::BASE_HP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gameTick,
    input  logic             pAlive,
    input  logic [POS_W-1:0] pPosition,
    input  logic [DMG_W-1:0] pDamageOut,
    input  logic             eAlive,
    input  logic [POS_W-1:0] ePosition,
    input  logic [DMG_W-1:0] eDamageOut,
    output logic             pMoveSCEN,
    output logic             pDamageSCEN,
    output logic [DMG_W-1:0] pDamageIn,
    output logic             eMoveSCEN,
    output logic             eDamageSCEN,
    output logic [DMG_W-1:0] eDamageIn,
    output logic [DMG_W-1:0] playerBaseHP,
    output logic [DMG_W-1:0] enemyBaseHP,
    output logic             gameOver,
    output logic             playerWins,
    output logic             tickOverrun
);

    lane_state_t state_reg, state_next;

    logic             p_alive_reg, e_alive_reg;
    logic [POS_W-1:0] p_pos_reg, e_pos_reg;
    logic [DMG_W-1:0] p_power_reg, e_power_reg;

    decision_t        dec_reg, dec_next;
    logic             hit_enemy_base, hit_player_base, contact;
    logic [DMG_W-1:0] p_dmg_in_reg, e_dmg_in_reg;
    logic             game_over_reg, player_wins_reg, overrun_reg;
    logic             p_base_zero, e_base_zero;
    logic             in_eval, in_apply;

    assign in_eval  = (state_reg == ST_EVAL);
    assign in_apply = (state_reg == ST_APPLY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (gameTick) state_next = ST_EVAL;
            ST_EVAL:  state_next = ST_APPLY;
            ST_APPLY: state_next = (p_base_zero || e_base_zero) ? ST_OVER : ST_IDLE;
            ST_OVER:  state_next = ST_OVER;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Inputs are frozen on the accepted tick so the decision ignores later churn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_alive_reg <= 1'b0;
            e_alive_reg <= 1'b0;
            p_pos_reg   <= '0;
            e_pos_reg   <= '0;
            p_power_reg <= '0;
            e_power_reg <= '0;
        end else if (state_reg == ST_IDLE && gameTick) begin
            p_alive_reg <= pAlive;
            e_alive_reg <= eAlive;
            p_pos_reg   <= pPosition;
            e_pos_reg   <= ePosition;
            p_power_reg <= pDamageOut;
            e_power_reg <= eDamageOut;
        end
    end

    always_comb begin
        dec_next        = '0;
        hit_enemy_base  = 1'b0;
        hit_player_base = 1'b0;
        contact         = p_alive_reg && e_alive_reg && in_contact(p_pos_reg, e_pos_reg, RANGE);
        if (contact) begin
            dec_next.p_hit = 1'b1;
            dec_next.e_hit = 1'b1;
        end else begin
            if (p_alive_reg) begin
                if (p_pos_reg != '0) dec_next.p_move = 1'b1;
                else                 hit_enemy_base  = 1'b1;
            end
            if (e_alive_reg) begin
                if (e_pos_reg != MAX_POS) dec_next.e_move  = 1'b1;
                else                      hit_player_base = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_reg      <= '0;
            p_dmg_in_reg <= '0;
            e_dmg_in_reg <= '0;
        end else if (in_eval) begin
            dec_reg <= dec_next;
            if (contact) begin
                p_dmg_in_reg <= e_power_reg;
                e_dmg_in_reg <= p_power_reg;
            end
        end
    end

    // Base health lands on the EVAL->APPLY edge, so APPLY sees the new zero flags.
    base_hp_counter #(.LOAD(BASE_HP)) u_player_base (
        .clk    (clk),
        .rst_n  (reset),
        .sub_en (in_eval && hit_player_base),
        .amount (e_power_reg),
        .count  (playerBaseHP),
        .zero   (p_base_zero)
    );

    base_hp_counter #(.LOAD(BASE_HP)) u_enemy_base (
        .clk    (clk),
        .rst_n  (reset),
        .sub_en (in_eval && hit_enemy_base),
        .amount (p_power_reg),
        .count  (enemyBaseHP),
        .zero   (e_base_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            game_over_reg   <= 1'b0;
            player_wins_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (in_apply && (p_base_zero || e_base_zero)) begin
                game_over_reg   <= 1'b1;
                player_wins_reg <= e_base_zero && !p_base_zero;
            end
            if (gameTick && (in_eval || in_apply)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign pMoveSCEN   = in_apply && dec_reg.p_move;
    assign pDamageSCEN = in_apply && dec_reg.p_hit;
    assign eMoveSCEN   = in_apply && dec_reg.e_move;
    assign eDamageSCEN = in_apply && dec_reg.e_hit;
    assign pDamageIn   = p_dmg_in_reg;
    assign eDamageIn   = e_dmg_in_reg;
    assign gameOver    = game_over_reg;
    assign playerWins  = player_wins_reg;
    assign tickOverrun = overrun_reg;

endmodule

// File: tb/tb_lane_combat_ctrl.sv
// Scoreboard bench for lane_combat_ctrl: ticks push predicted outcomes from a
// rule-level lane model; a negedge monitor compares whatever the DUT presents.
module tb_lane_combat_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       gameTick = 1'b0;
    logic       pAlive = 1'b0;
    logic [8:0] pPosition = '0;
    logic [7:0] pDamageOut = '0;
    logic       eAlive = 1'b0;
    logic [8:0] ePosition = '0;
    logic [7:0] eDamageOut = '0;
    logic       pMoveSCEN, pDamageSCEN, eMoveSCEN, eDamageSCEN;
    logic [7:0] pDamageIn, eDamageIn, playerBaseHP, enemyBaseHP;
    logic       gameOver, playerWins, tickOverrun;

    always #5 clk = ~clk;

    lane_combat_ctrl dut (
        .clk(clk), .reset(reset), .gameTick(gameTick),
        .pAlive(pAlive), .pPosition(pPosition), .pDamageOut(pDamageOut),
        .eAlive(eAlive), .ePosition(ePosition), .eDamageOut(eDamageOut),
        .pMoveSCEN(pMoveSCEN), .pDamageSCEN(pDamageSCEN), .pDamageIn(pDamageIn),
        .eMoveSCEN(eMoveSCEN), .eDamageSCEN(eDamageSCEN), .eDamageIn(eDamageIn),
        .playerBaseHP(playerBaseHP), .enemyBaseHP(enemyBaseHP),
        .gameOver(gameOver), .playerWins(playerWins), .tickOverrun(tickOverrun)
    );

    typedef struct {
        int due;
        bit pm, ph, em, eh;
        int pdi, edi;
        int php, ehp;
        bit over, pwin;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   m_php = 255, m_ehp = 255;
    bit   m_over = 0, m_pwin = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lane rules applied to one tick's inputs at the level of positions and health.
    function automatic exp_t model(input bit pa, input int pp, input int pd,
                                   input bit ea, input int ep, input int ed, input int due);
        exp_t x;
        bit   touch;
        x = '{default: 0};
        x.due = due;
        if (!m_over) begin
            touch = pa && ea && (pp < ep || (pp - ep) <= 1);
            if (touch) begin
                x.ph = 1; x.eh = 1;
                x.pdi = ed; x.edi = pd;
            end else begin
                if (pa) begin
                    if (pp != 0) x.pm = 1;
                    else m_ehp = (m_ehp > pd) ? m_ehp - pd : 0;
                end
                if (ea) begin
                    if (ep != 510) x.em = 1;
                    else m_php = (m_php > ed) ? m_php - ed : 0;
                end
                if (m_php == 0 || m_ehp == 0) begin
                    m_over = 1;
                    m_pwin = (m_ehp == 0) && (m_php != 0);
                end
            end
        end
        x.php = m_php; x.ehp = m_ehp; x.over = m_over; x.pwin = m_pwin;
        return x;
    endfunction

    // Monitor: strobes checked on the due cycle, base state one cycle later.
    initial begin
        exp_t x;
        exp_t post;
        bit   post_v;
        post_v = 0;
        forever begin
            @(negedge clk);
            if (reset == 1'b0) begin
                post_v = 0;
            end else begin
                if (post_v && cyc == post.due + 1) begin
                    check("playerBaseHP", playerBaseHP, post.php);
                    check("enemyBaseHP", enemyBaseHP, post.ehp);
                    check("gameOver", gameOver, post.over);
                    if (post.over) check("playerWins", playerWins, post.pwin);
                    post_v = 0;
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    x = sb.pop_front();
                    $display("txn cyc=%0d pm=%0b ph=%0b em=%0b eh=%0b pdi=%0d edi=%0d php=%0d ehp=%0d",
                             cyc, pMoveSCEN, pDamageSCEN, eMoveSCEN, eDamageSCEN,
                             pDamageIn, eDamageIn, playerBaseHP, enemyBaseHP);
                    check("pMoveSCEN", pMoveSCEN, x.pm);
                    check("pDamageSCEN", pDamageSCEN, x.ph);
                    check("eMoveSCEN", eMoveSCEN, x.em);
                    check("eDamageSCEN", eDamageSCEN, x.eh);
                    if (x.ph) check("pDamageIn", pDamageIn, x.pdi);
                    if (x.eh) check("eDamageIn", eDamageIn, x.edi);
                    post = x;
                    post_v = 1;
                end else begin
                    check("idle_strobes", {pMoveSCEN, pDamageSCEN, eMoveSCEN, eDamageSCEN}, 0);
                end
            end
        end
    end

    task automatic scramble();
        pAlive     = 1'($urandom);
        pPosition  = 9'($urandom);
        pDamageOut = 8'($urandom);
        eAlive     = 1'($urandom);
        ePosition  = 9'($urandom);
        eDamageOut = 8'($urandom);
    endtask

    task automatic tick(input bit pa, input int pp, input int pd,
                        input bit ea, input int ep, input int ed);
        @(posedge clk); #1;
        pAlive = pa; pPosition = pp[8:0]; pDamageOut = pd[7:0];
        eAlive = ea; ePosition = ep[8:0]; eDamageOut = ed[7:0];
        gameTick = 1'b1;
        sb.push_back(model(pa, pp, pd, ea, ep, ed, cyc + 2));
        @(posedge clk); #1;
        gameTick = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        gameTick = 1'b0;
        sb.delete();
        m_php = 255; m_ehp = 255; m_over = 0; m_pwin = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pp, ep;
        #12;
        check("rst_pMoveSCEN", pMoveSCEN, 0);
        check("rst_pDamageSCEN", pDamageSCEN, 0);
        check("rst_eMoveSCEN", eMoveSCEN, 0);
        check("rst_eDamageSCEN", eDamageSCEN, 0);
        check("rst_pDamageIn", pDamageIn, 0);
        check("rst_eDamageIn", eDamageIn, 0);
        check("rst_playerBaseHP", playerBaseHP, 255);
        check("rst_enemyBaseHP", enemyBaseHP, 255);
        check("rst_gameOver", gameOver, 0);
        check("rst_playerWins", playerWins, 0);
        check("rst_tickOverrun", tickOverrun, 0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        tick(1, 100, 5, 0, 0, 0);
        tick(1, 50, 8'h20, 1, 49, 8'h10);
        tick(1, 200, 3, 1, 300, 7);
        tick(1, 1, 9, 1, 509, 4);

        do_reset();
        tick(1, 0, 8'h80, 0, 0, 0);
        tick(1, 0, 8'h80, 0, 0, 0);
        tick(1, 100, 8'h80, 1, 20, 8'h11);
        check("over_playerWins", playerWins, 1);

        do_reset();
        tick(0, 0, 0, 1, 510, 8'hFF);
        tick(1, 300, 1, 1, 100, 1);
        check("enemy_win_gameOver", gameOver, 1);
        check("enemy_win_playerWins", playerWins, 0);

        do_reset();
        check("overrun_clear", tickOverrun, 0);
        @(posedge clk); #1;
        pAlive = 1; pPosition = 9'd100; pDamageOut = 8'd1; eAlive = 0;
        gameTick = 1'b1;
        sb.push_back(model(1, 100, 1, 0, 0, 0, cyc + 2));
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        gameTick = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("overrun_set", tickOverrun, 1);

        do_reset();
        tick(1, 0, 8'h80, 0, 0, 0);
        @(posedge clk); #1;
        pAlive = 1; pPosition = 9'd100; eAlive = 0;
        gameTick = 1'b1;
        @(posedge clk); #1;
        gameTick = 1'b0;
        @(posedge clk); #1;
        check("apply_pMoveSCEN", pMoveSCEN, 1);
        check("apply_enemyBaseHP", enemyBaseHP, 127);
        reset = 1'b0;
        sb.delete();
        m_php = 255; m_ehp = 255; m_over = 0; m_pwin = 0;
        #1;
        check("midrst_pMoveSCEN", pMoveSCEN, 0);
        check("midrst_enemyBaseHP", enemyBaseHP, 255);
        check("midrst_playerBaseHP", playerBaseHP, 255);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick(1, 100, 2, 0, 0, 0);

        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int t = 0; t < 30; t++) begin
                pp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 511));
                case ($urandom_range(0, 3))
                    0: ep = 510;
                    1: ep = (pp >= 2) ? pp - int'($urandom_range(0, 2)) : 0;
                    2: ep = (pp + 20 <= 511) ? pp + int'($urandom_range(1, 20)) : 511;
                    default: ep = int'($urandom_range(0, 511));
                endcase
                tick($urandom_range(0, 3) != 0, pp, int'($urandom_range(0, 255)),
                     $urandom_range(0, 3) != 0, ep, int'($urandom_range(0, 255)));
            end
            check("random_no_overrun", tickOverrun, 0);
        end

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
